// File: rtl/alu_resp_unit.sv
// alu_resp_unit: 32-bit ALU behind a valid/ready request port, with a 2-entry response FIFO.
// Define ALU_RESP_STATS_EN to add saturating op_count/err_count statistics ports.
module alu_resp_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   sel,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] y,
   output logic         cout,
   output logic         z_flag,
   output logic         rsp_err
`ifdef ALU_RESP_STATS_EN
   ,
   output logic [15:0]  op_count,
   output logic [7:0]   err_count
`endif
);
   typedef struct packed {
      logic [N-1:0] y;
      logic         cout;
      logic         z;
      logic         err;
   } ent_t;

   ent_t         ent;
   ent_t         mem [2];
   logic         wp, rp, push, pop, err, lt_u, lt_s;
   logic [1:0]   cnt;
   logic [N:0]   sum;
   logic [N-1:0] yc;
   logic         cc;

   assign err  = sel == 3'b110;
   assign sum  = {1'b0, a} + {1'b0, b};
   assign lt_u = a < b;
   assign lt_s = $signed(a) < $signed(b);

   always_comb begin
      yc = sel == 3'b000 ? a & b :
           sel == 3'b001 ? a | b :
           sel == 3'b010 ? sum[N-1:0] :
           sel == 3'b011 ? a - b :
           sel == 3'b100 ? a & ~b :
           sel == 3'b101 ? a | ~b :
           sel == 3'b111 ? {{(N-1){1'b0}}, lt_s} : '0;
      cc = sel == 3'b010 ? sum[N] : (sel == 3'b011 || sel == 3'b111) ? lt_u : 1'b0;
      // illegal requests store y = 0 yet report z_flag = 0
      ent = '{y: yc, cout: cc, z: !err && yc == '0, err: err};
   end

   assign req_ready = cnt != 2'd2;
   assign rsp_valid = cnt != 2'd0;
   assign push      = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;
   assign {y, cout, z_flag, rsp_err} = mem[rp];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push) begin
            mem[wp] <= ent;
            wp      <= !wp;
         end
         if (pop) rp <= !rp;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

`ifdef ALU_RESP_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count  <= '0;
         err_count <= '0;
      end else if (push) begin
         if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
         if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_alu_resp_unit.sv
// tb_alu_resp_unit: directed and randomized checks of alu_resp_unit against a queue-based reference model.
module tb_alu_resp_unit;
   logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0;
   logic        req_ready, rsp_valid, cout, z_flag, rsp_err;
   logic [31:0] a = '0, b = '0, y;
   logic [2:0]  sel = '0;
`ifdef ALU_RESP_STATS_EN
   logic [15:0] op_count;
   logic [7:0]  err_count;
   int          m_ops = 0, m_errs = 0;
`endif

   typedef struct {
      logic [31:0] y;
      logic        c;
      logic        z;
      logic        e;
   } rsp_t;

   rsp_t q[$];
   int   errors = 0, checks = 0;

   always #5 clk = ~clk;

   alu_resp_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .a(a), .b(b), .sel(sel), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .y(y), .cout(cout), .z_flag(z_flag), .rsp_err(rsp_err)
`ifdef ALU_RESP_STATS_EN
      , .op_count(op_count), .err_count(err_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic rsp_t model(input logic [31:0] x, input logic [31:0] w, input logic [2:0] s);
      rsp_t        r;
      logic [63:0] t;
      r.y = '0; r.c = 1'b0; r.e = 1'b0;
      t = {32'b0, x} + {32'b0, w};
      case (s)
         3'd0: r.y = x & w;
         3'd1: r.y = x | w;
         3'd2: begin r.y = t[31:0]; r.c = t[32]; end
         3'd3: begin r.y = x - w; r.c = x < w; end
         3'd4: r.y = x & ~w;
         3'd5: r.y = x | ~w;
         3'd7: begin r.y = ($signed(x) < $signed(w)) ? 32'd1 : 32'd0; r.c = x < w; end
         default: r.e = 1'b1;
      endcase
      r.z = !r.e && r.y == 0;
      return r;
   endfunction

   // One clock cycle: entered and left at posedge+1, checks the visible state before the edge.
   task automatic cycle(input logic v, input logic [31:0] ai, input logic [31:0] bi,
                        input logic [2:0] si, input logic rr);
      logic psh, pp;
      rsp_t r;
      req_valid = v; a = ai; b = bi; sel = si; rsp_ready = rr;
      #1;
      check("rsp_valid", rsp_valid, q.size() != 0);
      check("req_ready", req_ready, q.size() != 2);
      if (q.size() != 0) begin
         check("y", y, q[0].y);
         check("cout", cout, q[0].c);
         check("z_flag", z_flag, q[0].z);
         check("rsp_err", rsp_err, q[0].e);
      end
`ifdef ALU_RESP_STATS_EN
      check("op_count", op_count, m_ops);
      check("err_count", err_count, m_errs);
`endif
      psh = v && q.size() != 2;
      pp  = rr && q.size() != 0;
      r   = model(ai, bi, si);
      if (pp) void'(q.pop_front());
      if (psh) begin
         q.push_back(r);
`ifdef ALU_RESP_STATS_EN
         if (m_ops < 65535) m_ops++;
         if (r.e && m_errs < 255) m_errs++;
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic one(input logic [31:0] ai, input logic [31:0] bi, input logic [2:0] si,
                      input logic [31:0] ey, input logic ec, input logic ez, input logic ee);
      cycle(1'b1, ai, bi, si, 1'b1);
      check("dir_valid", rsp_valid, 1'b1);
      check("dir_y", y, ey);
      check("dir_cout", cout, ec);
      check("dir_z", z_flag, ez);
      check("dir_err", rsp_err, ee);
   endtask

   initial begin
      @(posedge clk);
      #1;
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_ready", req_ready, 1'b1);
      check("rst_y", y, 32'h0);
      check("rst_flags", {cout, z_flag, rsp_err}, 3'b000);
      rst = 1'b0;

      one(32'h19, 32'h20, 3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
      one(32'h19, 32'h20, 3'b001, 32'h39, 1'b0, 1'b0, 1'b0);
      one(32'h19, 32'h20, 3'b010, 32'h39, 1'b0, 1'b0, 1'b0);
      one(32'h19, 32'h20, 3'b100, 32'h19, 1'b0, 1'b0, 1'b0);
      one(32'h19, 32'h20, 3'b101, 32'hFFFFFFDF, 1'b0, 1'b0, 1'b0);
      one(32'h19, 32'h20, 3'b011, 32'hFFFFFFF9, 1'b1, 1'b0, 1'b0);
      one(32'h19, 32'h20, 3'b111, 32'h1, 1'b1, 1'b0, 1'b0);
      one(32'hFFFFFFFF, 32'h1, 3'b010, 32'h0, 1'b1, 1'b1, 1'b0);
      one(32'h5, 32'h7, 3'b110, 32'h0, 1'b0, 1'b0, 1'b1);
`ifdef ALU_RESP_STATS_EN
      check("dir_err_count", err_count, 8'd1);
      check("dir_op_count", op_count, 16'd9);
`endif
      cycle(1'b0, 0, 0, 0, 1'b1);
      check("drained", rsp_valid, 1'b0);

      cycle(1'b1, 32'd1, 32'd2, 3'b010, 1'b0);
      cycle(1'b1, 32'd3, 32'd4, 3'b010, 1'b0);
      cycle(1'b1, 32'd5, 32'd6, 3'b011, 1'b0);
      check("bp_ready", req_ready, 1'b0);
      check("bp_head", y, 32'd3);
      cycle(1'b1, 32'd5, 32'd6, 3'b011, 1'b1);
      check("bp_ready_back", req_ready, 1'b1);
      check("bp_second", y, 32'd7);
      cycle(1'b1, 32'd5, 32'd6, 3'b011, 1'b1);
      check("bp_third", y, 32'hFFFFFFFF);
      cycle(1'b0, 0, 0, 0, 1'b1);

      cycle(1'b1, 32'd9, 32'd9, 3'b010, 1'b0);
      cycle(1'b1, 32'd8, 32'd8, 3'b001, 1'b0);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", rsp_valid, 1'b0);
      check("mid_rst_ready", req_ready, 1'b1);
      check("mid_rst_y", y, 32'h0);
      check("mid_rst_flags", {cout, z_flag, rsp_err}, 3'b000);
      q.delete();
`ifdef ALU_RESP_STATS_EN
      check("mid_rst_ops", op_count, 16'd0);
      m_ops = 0;
      m_errs = 0;
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) cycle(1'b0, 0, 0, 0, 1'b1);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: ra = $urandom_range(0, 1) ? 32'hFFFFFFFF : 32'h80000000;
            2: rb = $urandom_range(0, 1) ? 32'h0 : 32'h7FFFFFFF;
            default: ;
         endcase
         cycle($urandom_range(0, 9) < 7, ra, rb, 3'($urandom_range(0, 7)),
               $urandom_range(0, 9) < 6);
      end

`ifdef ALU_RESP_STATS_EN
      for (int i = 0; i < 65537; i++) cycle(1'b1, $urandom, $urandom, 3'b110, 1'b1);
      check("sat_op_count", op_count, 16'hFFFF);
      check("sat_err_count", err_count, 8'hFF);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
